// File: rtl/midi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | midi_pkg: shared constants, parameter derivations and LED FSM states |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package midi_pkg;

    localparam int CLOCK_DEFAULT = 12_000_000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4
    } led_state_t;

    function automatic int hold_cycles(input int clock, input int hold_ms);
        return (clock / 1000) * hold_ms;
    endfunction

    function automatic int refresh_period(input int clock, input int refresh_hz);
        return clock / refresh_hz;
    endfunction

    // Bits needed to hold 0..max_value; never narrower than one bit.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/activity_stretch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | activity_stretch: retriggerable pulse stretcher for one LED channel  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module activity_stretch
    import midi_pkg::*;
#(
    parameter int HOLD_CYCLES = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic led
);

    localparam int CW = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);

    logic [CW-1:0] r_count;

    // led is registered from the counter so a strobe at edge k lights
    // the LED on edges k+1 .. k+HOLD_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            led     <= 1'b0;
        end else begin
            if (strobe)
                r_count <= HOLD_VAL;
            else if (r_count != '0)
                r_count <= r_count - CW'(1);
            led <= (r_count != '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/activity_led_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | activity_led_driver: stretches MIDI activity strobes and refreshes   |
// | a 74HC595 LED chain over SCK/RCK/SER.  Rev 1.0                       |
// +----------------------------------------------------------------------+
module activity_led_driver
    import midi_pkg::*;
#(
    parameter int PORTS      = 16,
    parameter int CLOCK      = CLOCK_DEFAULT,
    parameter int HOLD_MS    = 50,
    parameter int SCK_DIV    = 4,
    parameter int REFRESH_HZ = 1000,
    parameter int INVERT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] act_in,
    input  logic [PORTS-1:0] act_out,
    input  logic             lamp_test,
    output logic             sck,
    output logic             rck,
    output logic             ser,
    output logic             busy
);

    localparam int HOLD_CYCLES    = hold_cycles(CLOCK, HOLD_MS);
    localparam int REFRESH_PERIOD = refresh_period(CLOCK, REFRESH_HZ);
    localparam int CHAIN          = 2 * PORTS;
    localparam int RW             = cnt_width(REFRESH_PERIOD - 1);
    localparam int DW             = cnt_width(SCK_DIV - 1);
    localparam int BW             = cnt_width(CHAIN - 1);

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST     = DW'(SCK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(CHAIN - 1);
    localparam logic          INV_BIT      = (INVERT != 0);

    logic [PORTS-1:0] w_led_in;
    logic [PORTS-1:0] w_led_out;

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
        activity_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_in (
            .clk    (clk),
            .rst_n  (rst_n),
            .strobe (act_in[gi]),
            .led    (w_led_in[gi])
        );
        activity_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_out (
            .clk    (clk),
            .rst_n  (rst_n),
            .strobe (act_out[gi]),
            .led    (w_led_out[gi])
        );
    end

    // Refresh timebase; the tick is registered so the first frame's LOAD
    // lands one cycle after the tick cycle.
    logic [RW-1:0] r_refresh;
    logic          r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= (r_refresh == REFRESH_LAST);
            if (r_refresh == REFRESH_LAST)
                r_refresh <= '0;
            else
                r_refresh <= r_refresh + RW'(1);
        end
    end

    // First-shifted bit sits at the MSB: act_out[PORTS-1] .. act_in[0].
    logic [CHAIN-1:0] w_snapshot;
    assign w_snapshot = {w_led_out, w_led_in} | {CHAIN{lamp_test}};

    led_state_t       r_state, w_state_nx;
    logic [DW-1:0]    r_div, w_div_nx;
    logic [BW-1:0]    r_bit, w_bit_nx;
    logic [CHAIN-1:0] r_shreg, w_shreg_nx;
    logic             w_ser_nx;
    logic             w_div_done;

    assign w_div_done = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            sck     <= 1'b0;
            rck     <= 1'b0;
            ser     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_div   <= w_div_nx;
            r_bit   <= w_bit_nx;
            r_shreg <= w_shreg_nx;
            // Pins are decoded from the next state so they align with it.
            sck     <= (w_state_nx == ST_SHIFT_HI);
            rck     <= (w_state_nx == ST_LATCH);
            busy    <= (w_state_nx != ST_IDLE);
            ser     <= w_ser_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_div_nx   = r_div;
        w_bit_nx   = r_bit;
        w_shreg_nx = r_shreg;
        w_ser_nx   = ser;
        unique case (r_state)
            ST_IDLE: begin
                // Ticks seen outside IDLE are simply dropped.
                if (r_tick)
                    w_state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                w_shreg_nx = w_snapshot;
                w_bit_nx   = '0;
                w_div_nx   = '0;
                w_ser_nx   = w_snapshot[CHAIN-1] ^ INV_BIT;
                w_state_nx = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (w_div_done) begin
                    w_div_nx   = '0;
                    w_state_nx = ST_SHIFT_HI;
                end else begin
                    w_div_nx = r_div + DW'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (w_div_done) begin
                    w_div_nx = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_nx = ST_LATCH;
                    end else begin
                        w_shreg_nx = {r_shreg[CHAIN-2:0], 1'b0};
                        w_bit_nx   = r_bit + BW'(1);
                        w_ser_nx   = w_shreg_nx[CHAIN-1] ^ INV_BIT;
                        w_state_nx = ST_SHIFT_LO;
                    end
                end else begin
                    w_div_nx = r_div + DW'(1);
                end
            end
            ST_LATCH: begin
                if (w_div_done) begin
                    w_div_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_div_nx = r_div + DW'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
